btb_update_ctrl: RTL and testbench

Sequencing controller for the branch target buffer write port. It buffers branch-resolution updates coming out of the EX stage in a small FIFO and drains them into the BTB one per cycle. It also runs a set-by-set invalidate walk when a flush is requested, for example on a context switch or a `fence.i`. It sits between the EX-stage branch unit and the BTB's `update` / `updatePC` / `updateTarget` / `mispredicted` inputs, plus the BTB's invalidate port.

---
 rtl/btb_update_ctrl_if.sv | 38 +++
 rtl/btb_update_ctrl.sv | 149 ++++++++++++++
 tb/tb_btb_update_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_ctrl_if.sv
// Signal bundle between the EX-stage branch unit, the BTB write/invalidate ports
// and btb_update_ctrl. The master modport is the controller's view.
interface btb_update_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int SETS  = 8
) ();
  localparam int IW = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ex_valid;
  logic [31:0]   ex_pc;
  logic [31:0]   ex_target;
  logic          ex_mispredicted;
  logic          ex_ready;
  logic          flush_req;
  logic          hold;
  logic          update;
  logic [31:0]   updatePC;
  logic [31:0]   updateTarget;
  logic          mispredicted;
  logic          inv_valid;
  logic [IW-1:0] inv_index;
  logic          flush_busy;
  logic [CW-1:0] count;
  logic          drop_err;

  modport master (
    input  ex_valid, ex_pc, ex_target, ex_mispredicted, flush_req, hold,
    output ex_ready, update, updatePC, updateTarget, mispredicted,
           inv_valid, inv_index, flush_busy, count, drop_err
  );

  modport slave (
    output ex_valid, ex_pc, ex_target, ex_mispredicted, flush_req, hold,
    input  ex_ready, update, updatePC, updateTarget, mispredicted,
           inv_valid, inv_index, flush_busy, count, drop_err
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: queues branch-resolution updates, drains one per cycle,
// and walks every BTB set for invalidation on a flush request.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | accept/drain updates; flush_req starts a walk
//   ST_FLUSH | invalidate sets 0..SETS-1, one per cycle; EX updates are dropped
module btb_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int SETS  = 8
) (
  input logic               clk,
  input logic               reset,
  btb_update_ctrl_if.master bus
);
  localparam int IW = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(SETS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] walk_q, walk_d;
  logic          inv_valid_q;
  logic          flush_busy_q;
  logic          drop_err_q;
  logic          fifo_clear;

  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      tgt_mem [DEPTH];
  logic [DEPTH-1:0] mis_mem;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;

  logic ex_ready_c;
  logic update_c;
  logic push;
  logic pop;
  logic overflow;

  // Handshake outputs are decoded straight from registered state.
  always_comb begin
    ex_ready_c = (state_q == ST_IDLE) && (count_q < FULL) && !reset;
    update_c   = (state_q == ST_IDLE) && (count_q != '0) && !bus.hold && !reset;
  end

  // A flush in the same cycle discards the EX entry instead of queueing it.
  assign push     = bus.ex_valid && ex_ready_c && !bus.flush_req;
  assign pop      = update_c;
  assign overflow = (state_q == ST_IDLE) && bus.ex_valid && (count_q == FULL) &&
                    !bus.flush_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      walk_q       <= '0;
      inv_valid_q  <= 1'b0;
      flush_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_q       <= walk_d;
      inv_valid_q  <= (state_d == ST_FLUSH);
      flush_busy_q <= (state_d == ST_FLUSH);
    end
  end

  always_comb begin
    state_d    = state_q;
    walk_d     = walk_q;
    fifo_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_d    = ST_FLUSH;
          walk_d     = '0;
          fifo_clear = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (bus.flush_req) begin
          walk_d = '0;
        end else if (walk_q == LAST) begin
          state_d = ST_IDLE;
          walk_d  = '0;
        end else begin
          walk_d = walk_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        walk_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (fifo_clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= bus.ex_pc;
      tgt_mem[wr_ptr_q] <= bus.ex_target;
      mis_mem[wr_ptr_q] <= bus.ex_mispredicted;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_err_q <= 1'b0;
    end else if (overflow) begin
      drop_err_q <= 1'b1;
    end
  end

  assign bus.ex_ready     = ex_ready_c;
  assign bus.update       = update_c;
  assign bus.updatePC     = pc_mem[rd_ptr_q];
  assign bus.updateTarget = tgt_mem[rd_ptr_q];
  assign bus.mispredicted = mis_mem[rd_ptr_q];
  assign bus.inv_valid    = inv_valid_q;
  assign bus.inv_index    = walk_q;
  assign bus.flush_busy   = flush_busy_q;
  assign bus.count        = count_q;
  assign bus.drop_err     = drop_err_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl (DEPTH=4, SETS=8) with hand-computed expectations.
module tb_btb_update_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  btb_update_ctrl_if #(.DEPTH(4), .SETS(8)) bus ();

  btb_update_ctrl #(.DEPTH(4), .SETS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid        = 1'b0;
    bus.ex_pc           = '0;
    bus.ex_target       = '0;
    bus.ex_mispredicted = 1'b0;
    bus.flush_req       = 1'b0;
    bus.hold            = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    #1;
    check("rst_ex_ready_low", 32'(bus.ex_ready), 0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    do_reset();

    check("rst_ex_ready",   32'(bus.ex_ready), 1);
    check("rst_count",      32'(bus.count), 0);
    check("rst_update",     32'(bus.update), 0);
    check("rst_inv_valid",  32'(bus.inv_valid), 0);
    check("rst_inv_index",  32'(bus.inv_index), 0);
    check("rst_flush_busy", 32'(bus.flush_busy), 0);
    check("rst_drop_err",   32'(bus.drop_err), 0);

    // single update
    bus.ex_valid        = 1'b1;
    bus.ex_pc           = 32'h0000_1040;
    bus.ex_target       = 32'h0000_2000;
    bus.ex_mispredicted = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("single_update", 32'(bus.update), 1);
    check("single_pc",     bus.updatePC, 32'h0000_1040);
    check("single_tgt",    bus.updateTarget, 32'h0000_2000);
    check("single_mis",    32'(bus.mispredicted), 1);
    check("single_count1", 32'(bus.count), 1);
    tick();
    #1;
    check("single_count0", 32'(bus.count), 0);
    check("single_upd0",   32'(bus.update), 0);

    // streaming: push every cycle, one write per cycle, occupancy stays at 1
    for (int i = 0; i < 8; i++) begin
      bus.ex_valid        = 1'b1;
      bus.ex_pc           = 32'h0000_3000 + 32'(4 * i);
      bus.ex_target       = 32'h0000_5000 + 32'(i);
      bus.ex_mispredicted = i[0];
      #1;
      check("stream_ready", 32'(bus.ex_ready), 1);
      if (i == 0) begin
        check("stream_upd_first", 32'(bus.update), 0);
        check("stream_cnt_first", 32'(bus.count), 0);
      end else begin
        check("stream_update", 32'(bus.update), 1);
        check("stream_pc",     bus.updatePC, 32'h0000_3000 + 32'(4 * (i - 1)));
        check("stream_tgt",    bus.updateTarget, 32'h0000_5000 + 32'(i - 1));
        check("stream_mis",    32'(bus.mispredicted), 32'((i - 1) & 1));
        check("stream_count",  32'(bus.count), 1);
      end
      tick();
    end
    idle_inputs();
    #1;
    check("stream_last_pc", bus.updatePC, 32'h0000_301c);
    tick();
    #1;
    check("stream_drained", 32'(bus.count), 0);
    check("stream_no_drop", 32'(bus.drop_err), 0);

    // back-pressure: 5 pushes with hold, the 5th overflows
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ex_valid  = 1'b1;
      bus.ex_pc     = 32'h0000_0100 + 32'(4 * i);
      bus.ex_target = 32'h0000_0900 + 32'(i);
      #1;
      check("bp_ready",    32'(bus.ex_ready), (i < 4) ? 1 : 0);
      check("bp_no_write", 32'(bus.update), 0);
      tick();
    end
    bus.ex_valid = 1'b0;
    #1;
    check("bp_count_full", 32'(bus.count), 4);
    check("bp_drop_err",   32'(bus.drop_err), 1);
    bus.hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_update", 32'(bus.update), 1);
      check("bp_pc",     bus.updatePC, 32'h0000_0100 + 32'(4 * i));
      check("bp_tgt",    bus.updateTarget, 32'h0000_0900 + 32'(i));
      tick();
    end
    #1;
    check("bp_count_empty", 32'(bus.count), 0);
    check("bp_drop_sticky", 32'(bus.drop_err), 1);

    // flush with 3 stale entries held back
    do_reset();
    check("fl_drop_cleared", 32'(bus.drop_err), 0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_valid = 1'b1;
      bus.ex_pc    = 32'h0000_0700 + 32'(4 * i);
      tick();
    end
    bus.ex_valid  = 1'b0;
    bus.flush_req = 1'b1;
    #1;
    check("fl_pre_count", 32'(bus.count), 3);
    check("fl_pre_inv",   32'(bus.inv_valid), 0);
    tick();
    bus.flush_req = 1'b0;
    bus.hold      = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.ex_valid = (k == 2);
      bus.ex_pc    = 32'h0000_0dd0;
      #1;
      check("fl_inv_valid", 32'(bus.inv_valid), 1);
      check("fl_inv_index", 32'(bus.inv_index), 32'(k));
      check("fl_busy",      32'(bus.flush_busy), 1);
      check("fl_no_update", 32'(bus.update), 0);
      check("fl_count",     32'(bus.count), 0);
      check("fl_not_ready", 32'(bus.ex_ready), 0);
      tick();
    end
    bus.ex_valid = 1'b0;
    #1;
    check("fl_done_inv",   32'(bus.inv_valid), 0);
    check("fl_done_busy",  32'(bus.flush_busy), 0);
    check("fl_done_ready", 32'(bus.ex_ready), 1);
    check("fl_done_count", 32'(bus.count), 0);
    check("fl_done_upd",   32'(bus.update), 0);
    check("fl_silent_drop", 32'(bus.drop_err), 0);

    // restart the walk at index 5
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rs_index_a", 32'(bus.inv_index), 32'(k));
      if (k == 5) bus.flush_req = 1'b1;
      tick();
    end
    bus.flush_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rs_index_b", 32'(bus.inv_index), 32'(k));
      check("rs_valid",   32'(bus.inv_valid), 1);
      tick();
    end
    #1;
    check("rs_done_inv",   32'(bus.inv_valid), 0);
    check("rs_done_ready", 32'(bus.ex_ready), 1);

    // collision: queued write drains in the flush_req cycle; EX entry discarded
    bus.ex_valid  = 1'b1;
    bus.ex_pc     = 32'h0000_0a00;
    bus.ex_target = 32'h0000_0b00;
    tick();
    bus.ex_pc     = 32'h0000_0c00;
    bus.flush_req = 1'b1;
    #1;
    check("col_update",  32'(bus.update), 1);
    check("col_pc",      bus.updatePC, 32'h0000_0a00);
    check("col_inv_off", 32'(bus.inv_valid), 0);
    tick();
    idle_inputs();
    #1;
    check("col_count", 32'(bus.count), 0);
    check("col_inv",   32'(bus.inv_valid), 1);
    check("col_idx",   32'(bus.inv_index), 0);
    check("col_no_upd", 32'(bus.update), 0);
    for (int k = 0; k < 8; k++) tick();
    #1;
    check("col_idle_ready", 32'(bus.ex_ready), 1);
    check("col_count_end",  32'(bus.count), 0);
    check("col_drop_err",   32'(bus.drop_err), 0);

    // reset in the middle of a walk
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("mr_index", 32'(bus.inv_index), 32'(k));
      if (k == 3) reset = 1'b1;
      tick();
    end
    #1;
    check("mr_inv_valid", 32'(bus.inv_valid), 0);
    check("mr_busy",      32'(bus.flush_busy), 0);
    check("mr_count",     32'(bus.count), 0);
    check("mr_index0",    32'(bus.inv_index), 0);
    reset = 1'b0;
    #1;
    check("mr_idle_ready", 32'(bus.ex_ready), 1);
    tick();
    #1;
    check("mr_stays_idle", 32'(bus.inv_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
